// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: state encoding, register index width
// and the bundle of pipeline-register control bits with its canned patterns.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_BUSY = 1'b1;

  typedef enum logic {
    S_RUN     = ST_RUN,
    S_MD_BUSY = ST_MD_BUSY
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_bubble;
  } ctrl_t;

  // Field order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble
  localparam ctrl_t CTRL_RUN   = 6'b110100;
  localparam ctrl_t CTRL_FLUSH = 6'b111110;
  localparam ctrl_t CTRL_STALL = 6'b000110;
  localparam ctrl_t CTRL_HOLD  = 6'b000001;
  localparam ctrl_t CTRL_RESET = 6'b001011;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX hazard sources in, pipeline-register controls out.
// The pipeline drives through the master modport; the controller uses slave.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             MemRead_ex;
  reg_idx_t         rdAddr_ex;
  reg_idx_t         rs1Addr_id;
  reg_idx_t         rs2Addr_id;
  logic             rs1Used_id;
  logic             rs2Used_id;
  logic             BranchTaken_ex;
  logic             MulDivStart_ex;
  logic             MulDivDone;

  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Flush;
  logic             EX_MEM_Bubble;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MulDivStart_ex, MulDivDone,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Bubble, md_timeout, stall_cycles
  );

  modport slave (
    input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MulDivStart_ex, MulDivDone,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Bubble, md_timeout, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the ID instruction.
// x0 is hardwired, so a load targeting it never creates a dependency.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic     mem_read_ex,
  input  reg_idx_t rd_addr_ex,
  input  reg_idx_t rs1_addr_id,
  input  reg_idx_t rs2_addr_id,
  input  logic     rs1_used_id,
  input  logic     rs2_used_id,
  output logic     load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used_id && (rs1_addr_id == rd_addr_ex);
  assign rs2_hit  = rs2_used_id && (rs2_addr_id == rd_addr_ex);
  assign load_use = mem_read_ex && (rd_addr_ex != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes and mul/div
// holds with timeout, plus a saturating count of PC-stalled cycles.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int                  MD_CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [MD_CNT_W-1:0] MD_LIMIT = MD_CNT_W'(MD_TIMEOUT);

  state_e              state_q,      state_d;
  logic [MD_CNT_W-1:0] md_cnt_q,     md_cnt_d;
  logic                md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]    stall_q,      stall_d;

  ctrl_t ctrl;
  logic  load_use;

  hazard_detect u_hazard_detect (
    .mem_read_ex (bus.MemRead_ex),
    .rd_addr_ex  (bus.rdAddr_ex),
    .rs1_addr_id (bus.rs1Addr_id),
    .rs2_addr_id (bus.rs2Addr_id),
    .rs1_used_id (bus.rs1Used_id),
    .rs2_used_id (bus.rs2Used_id),
    .load_use    (load_use)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    ctrl         = CTRL_RUN;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;

    unique case (state_q)
      S_RUN: begin
        if (bus.BranchTaken_ex) begin
          ctrl = CTRL_FLUSH;
        end else if (bus.MulDivStart_ex) begin
          // A unit that answers in the start cycle needs no hold at all.
          if (!bus.MulDivDone) begin
            ctrl     = CTRL_HOLD;
            md_cnt_d = MD_CNT_W'(1);
            state_d  = S_MD_BUSY;
          end
        end else if (load_use) begin
          ctrl = CTRL_STALL;
        end
      end

      S_MD_BUSY: begin
        if (bus.MulDivDone || (md_cnt_q >= MD_LIMIT)) begin
          // Release: EX result (or whatever is there on timeout) moves on.
          state_d  = S_RUN;
          md_cnt_d = '0;
          if (!bus.MulDivDone) md_timeout_d = 1'b1;
        end else begin
          ctrl     = CTRL_HOLD;
          md_cnt_d = md_cnt_q + 1'b1;
        end
      end

      default: state_d = S_RUN;
    endcase

    if (!Reset_n) ctrl = CTRL_RESET;
  end

  always_comb begin
    stall_d = stall_q;
    if (!ctrl.pc_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and wins over the next-state logic.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q      <= S_RUN;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.PCWrite       = ctrl.pc_write;
  assign bus.IF_ID_Write   = ctrl.if_id_write;
  assign bus.IF_ID_Flush   = ctrl.if_id_flush;
  assign bus.ID_EX_Write   = ctrl.id_ex_write;
  assign bus.ID_EX_Flush   = ctrl.id_ex_flush;
  assign bus.EX_MEM_Bubble = ctrl.ex_mem_bubble;
  assign bus.md_timeout    = md_timeout_q;
  assign bus.stall_cycles  = stall_q;

endmodule
